sram_write_sequencer: RTL and testbench

Parametrised SRAM write sequencer for the network's data path. On each start request it writes a burst of words from the compute side into on-chip SRAM, holding write-enable for a configurable number of cycles per word. It auto-increments the SRAM address and wraps at a configurable depth (one frame, e.g. 784 pixels). It sits between the display/compute completion signal and the SRAM macro.

---
 rtl/sram_write_sequencer.sv | 140 ++++++++++++++
 tb/tb_sram_write_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_write_sequencer.sv
// Burst SRAM write sequencer: on each start edge, latches din and holds
// sram_wren per word, auto-incrementing sram_addr with wrap at DEPTH.
// Optional sticky dropped-request flag: define SRAM_SEQ_OVERRUN_EN.
module sram_write_sequencer #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 784,
    parameter int WR_CYCLES = 2,
    parameter int BURST_LEN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear,
    input  logic [DATA_W-1:0] din,
    output logic              sram_wren,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_data,
    output logic              addr_incre,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
    output logic [1:0]        state_dbg
);

    localparam int WC_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam int BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WC_W-1:0] wr_cnt, wr_cnt_nxt;
    logic [BC_W-1:0] burst_cnt, burst_cnt_nxt;
    logic            start_q;
    logic            req;
    logic            last_wr;
    logic            wrap;

    // A request is a rising edge of start; there is no back-pressure, so an
    // edge arriving while busy (or with clear) is simply dropped.
    assign req       = start & ~start_q;
    assign last_wr   = (state == WRITE) && (wr_cnt == WC_W'(WR_CYCLES - 1));
    assign wrap      = last_wr && (sram_addr == ADDR_W'(DEPTH - 1));
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_comb begin
        state_nxt     = state;
        wr_cnt_nxt    = wr_cnt;
        burst_cnt_nxt = burst_cnt;
        sram_wren     = 1'b0;
        addr_incre    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt     = LATCH;
                    burst_cnt_nxt = BC_W'(BURST_LEN - 1);
                end
            end
            LATCH: begin
                state_nxt  = WRITE;
                wr_cnt_nxt = '0;
            end
            WRITE: begin
                sram_wren = 1'b1;
                if (last_wr) begin
                    addr_incre = ~clear;
                    if (burst_cnt != '0) begin
                        state_nxt     = LATCH;
                        burst_cnt_nxt = burst_cnt - BC_W'(1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    wr_cnt_nxt = wr_cnt + WC_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Abort wins over everything the FSM decided above.
        if (clear) begin
            state_nxt     = IDLE;
            wr_cnt_nxt    = '0;
            burst_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_cnt     <= '0;
            burst_cnt  <= '0;
            start_q    <= 1'b0;
            sram_addr  <= '0;
            sram_data  <= '0;
            frame_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_cnt    <= wr_cnt_nxt;
            burst_cnt <= burst_cnt_nxt;
            start_q   <= start;
            if (clear) begin
                sram_addr  <= '0;
                frame_done <= 1'b0;
            end else begin
                frame_done <= wrap;
                if (addr_incre) begin
                    sram_addr <= wrap ? '0 : sram_addr + ADDR_W'(1);
                end
                if (state == LATCH) begin
                    sram_data <= din;
                end
            end
        end
    end

`ifdef SRAM_SEQ_OVERRUN_EN
    logic overrun_q;

    // Set beats clear so a request coincident with clear is still recorded.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (req && (clear || busy)) begin
            overrun_q <= 1'b1;
        end else if (clear) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_sram_write_sequencer.sv
// Self-checking bench for sram_write_sequencer: three parameterisations, a
// burst-timeline model compared every cycle, plus literal spot checks.
module tb_sram_write_sequencer;

    localparam int W0 = 2, B0 = 1, D0 = 784;
    localparam int W1 = 4, B1 = 3, D1 = 784;
    localparam int W2 = 1, B2 = 1, D2 = 4;

`ifdef SRAM_SEQ_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    int pw[3] = '{W0, W1, W2};
    int pb[3] = '{B0, B1, B2};
    int pd[3] = '{D0, D1, D2};

    logic        clk;
    logic        reset;
    logic        st_i[3];
    logic        cl_i[3];
    logic [15:0] din_i[3];

    logic        wren_o[3];
    logic [9:0]  addr_o[3];
    logic [15:0] data_o[3];
    logic        incre_o[3];
    logic        busy_o[3];
    logic        fd_o[3];
    logic        ovr_o[3];
    logic [1:0]  st_o[3];

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    sram_write_sequencer #(.DATA_W(16), .ADDR_W(10), .DEPTH(D0), .WR_CYCLES(W0), .BURST_LEN(B0)) u0 (
        .clk(clk), .reset(reset), .start(st_i[0]), .clear(cl_i[0]), .din(din_i[0]),
        .sram_wren(wren_o[0]), .sram_addr(addr_o[0]), .sram_data(data_o[0]),
        .addr_incre(incre_o[0]), .busy(busy_o[0]), .frame_done(fd_o[0]),
        .overrun(ovr_o[0]), .state_dbg(st_o[0]));

    sram_write_sequencer #(.DATA_W(16), .ADDR_W(10), .DEPTH(D1), .WR_CYCLES(W1), .BURST_LEN(B1)) u1 (
        .clk(clk), .reset(reset), .start(st_i[1]), .clear(cl_i[1]), .din(din_i[1]),
        .sram_wren(wren_o[1]), .sram_addr(addr_o[1]), .sram_data(data_o[1]),
        .addr_incre(incre_o[1]), .busy(busy_o[1]), .frame_done(fd_o[1]),
        .overrun(ovr_o[1]), .state_dbg(st_o[1]));

    sram_write_sequencer #(.DATA_W(16), .ADDR_W(10), .DEPTH(D2), .WR_CYCLES(W2), .BURST_LEN(B2)) u2 (
        .clk(clk), .reset(reset), .start(st_i[2]), .clear(cl_i[2]), .din(din_i[2]),
        .sram_wren(wren_o[2]), .sram_addr(addr_o[2]), .sram_data(data_o[2]),
        .addr_incre(incre_o[2]), .busy(busy_o[2]), .frame_done(fd_o[2]),
        .overrun(ovr_o[2]), .state_dbg(st_o[2]));

    // ---------------- model ----------------
    // A request opens a window of pb*(pw+1) busy cycles; position k inside it
    // decides latch (k mod per == 0), write, and address step (phase == pw).
    bit          m_act[3];
    int          m_k[3];
    int          m_addr[3];
    logic [15:0] m_data[3];
    bit          m_fd[3];
    bit          m_ovr[3];
    bit          m_sq[3];
    bit          cmp_en = 1'b0;

    task automatic model_step(input int i);
        int per;
        bit req;
        per = pw[i] + 1;
        req = st_i[i] && !m_sq[i];
        if (reset) begin
            m_act[i] = 0; m_k[i] = 0; m_addr[i] = 0; m_data[i] = '0;
            m_fd[i] = 0; m_ovr[i] = 0; m_sq[i] = 0;
            return;
        end
        m_sq[i] = st_i[i];
        if (cl_i[i]) begin
            m_act[i] = 0; m_k[i] = 0; m_addr[i] = 0; m_fd[i] = 0;
            m_ovr[i] = OVR_EN && req;
        end else begin
            m_fd[i] = 0;
            if (m_act[i]) begin
                if (m_k[i] % per == 0) m_data[i] = din_i[i];
                if (m_k[i] % per == pw[i]) begin
                    m_fd[i]   = (m_addr[i] == pd[i] - 1);
                    m_addr[i] = (m_addr[i] + 1) % pd[i];
                end
                m_k[i]++;
                if (m_k[i] == pb[i] * per) begin
                    m_act[i] = 0;
                    m_k[i]   = 0;
                end
                if (req && OVR_EN) m_ovr[i] = 1;
            end else if (req) begin
                m_act[i] = 1;
                m_k[i]   = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) model_step(i);
        cmp_en = 1'b1;
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                int ph;
                ph = m_k[i] % (pw[i] + 1);
                check($sformatf("u%0d.busy", i), busy_o[i], m_act[i]);
                check($sformatf("u%0d.wren", i), wren_o[i], m_act[i] && ph != 0);
                check($sformatf("u%0d.incre", i), incre_o[i], m_act[i] && ph == pw[i] && !cl_i[i]);
                check($sformatf("u%0d.state", i), st_o[i], !m_act[i] ? 0 : (ph == 0 ? 1 : 2));
                check($sformatf("u%0d.addr", i), addr_o[i], m_addr[i]);
                check($sformatf("u%0d.data", i), data_o[i], m_data[i]);
                check($sformatf("u%0d.frame_done", i), fd_o[i], m_fd[i]);
                check($sformatf("u%0d.overrun", i), ovr_o[i], m_ovr[i]);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int busy_n, inc_n, fd_n;
        logic [9:0] exp_addr[4];
        exp_addr = '{10'd1, 10'd2, 10'd3, 10'd0};
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st_i[i] = 1'b0; cl_i[i] = 1'b0; din_i[i] = '0;
        end
        st_i[2] = 1'b1;             // held through reset on u2
        repeat (3) tick();
        check("reset.busy", busy_o[0], 0);
        check("reset.addr", addr_o[0], 0);
        reset = 1'b0;

        // start held out of reset counts as a request
        repeat (3) tick();
        st_i[2] = 1'b0;
        check("held_reset.addr", addr_o[2], 1);
        tick(); cl_i[2] = 1'b1;
        tick(); cl_i[2] = 1'b0;
        check("clear_idle.addr", addr_o[2], 0);

        // single word, defaults; request in last WRITE cycle is ignored
        tick(); din_i[0] = 16'h00A5; st_i[0] = 1'b1;        // cycle 0
        tick(); st_i[0] = 1'b0;                             // cycle 1
        check("t1.busy_c1", busy_o[0], 1);
        check("t1.wren_c1", wren_o[0], 0);
        tick();                                             // cycle 2
        check("t1.wren_c2", wren_o[0], 1);
        check("t1.data_c2", data_o[0], 16'h00A5);
        tick(); st_i[0] = 1'b1;                             // cycle 3
        check("t1.incre_c3", incre_o[0], 1);
        tick(); st_i[0] = 1'b0;                             // cycle 4
        check("t1.busy_c4", busy_o[0], 0);
        check("t1.addr_c4", addr_o[0], 1);
        tick(); st_i[0] = 1'b1;                             // cycle 5
        tick(); st_i[0] = 1'b0;                             // cycle 6
        check("t1.reaccept_c6", busy_o[0], 1);
        repeat (4) tick();
        cl_i[0] = 1'b1;
        tick(); cl_i[0] = 1'b0;
        check("t1.clear_ovr", ovr_o[0], 0);

        // burst of 3 words, WR_CYCLES=4, din changing every cycle
        busy_n = 0; inc_n = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            din_i[1] = 16'h1000 + 16'(c) * 16'h0111;
            st_i[1] = (c == 0);
            if (busy_o[1]) busy_n++;
            if (incre_o[1]) inc_n++;
            if (c == 2)  check("t2.word0", data_o[1], 16'h1111);
            if (c == 7)  check("t2.word1", data_o[1], 16'h1666);
            if (c == 12) check("t2.word2", data_o[1], 16'h1BBB);
        end
        check("t2.busy_cycles", busy_n, 15);
        check("t2.incre_pulses", inc_n, 3);
        check("t2.addr_end", addr_o[1], 3);

        // clear during 2nd WRITE cycle
        tick(); st_i[1] = 1'b1;                             // cycle 0
        tick(); st_i[1] = 1'b0;                             // cycle 1
        tick();                                             // cycle 2
        tick(); cl_i[1] = 1'b1;                             // cycle 3
        tick(); cl_i[1] = 1'b0;                             // cycle 4
        check("t5.busy", busy_o[1], 0);
        check("t5.wren", wren_o[1], 0);
        check("t5.addr", addr_o[1], 0);
        check("t5.incre", incre_o[1], 0);

        // DEPTH=4 wrap
        fd_n = 0;
        for (int r = 0; r < 4; r++) begin
            tick(); st_i[2] = 1'b1; if (fd_o[2]) fd_n++;
            tick(); st_i[2] = 1'b0; if (fd_o[2]) fd_n++;
            tick(); if (fd_o[2]) fd_n++;
            tick(); if (fd_o[2]) fd_n++;
            check($sformatf("t3.addr%0d", r), addr_o[2], exp_addr[r]);
            check($sformatf("t3.fd%0d", r), fd_o[2], r == 3);
        end
        tick(); if (fd_o[2]) fd_n++;
        check("t3.fd_pulses", fd_n, 1);

        // start held high 20 cycles: exactly one word
        busy_n = 0; inc_n = 0;
        st_i[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (busy_o[0]) busy_n++;
            if (incre_o[0]) inc_n++;
        end
        st_i[0] = 1'b0;
        check("t4.incre_pulses", inc_n, 1);
        check("t4.busy_cycles", busy_n, 3);
        check("t4.ovr", ovr_o[0], 0);

        // overrun: edge while busy, then clear, then request with clear
        tick(); st_i[0] = 1'b1;
        tick(); st_i[0] = 1'b0;
        tick(); st_i[0] = 1'b1;
        tick(); st_i[0] = 1'b0;
        check("t6.ovr_set", ovr_o[0], OVR_EN);
        repeat (3) tick();
        check("t6.ovr_sticky", ovr_o[0], OVR_EN);
        cl_i[0] = 1'b1;
        tick(); cl_i[0] = 1'b0;
        check("t6.ovr_clr", ovr_o[0], 0);
        tick(); cl_i[0] = 1'b1; st_i[0] = 1'b1;
        tick(); cl_i[0] = 1'b0; st_i[0] = 1'b0;
        check("t6.ovr_coinc", ovr_o[0], OVR_EN);
        check("t6.coinc_busy", busy_o[0], 0);
        tick(); cl_i[0] = 1'b1;
        tick(); cl_i[0] = 1'b0;
        check("t6.ovr_clr2", ovr_o[0], 0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
